// File: rtl/avalon_line_master_if.sv
// Avalon-MM burst bus between the line master and the system interconnect.
// Parameters: AW address width, DW data width, BCW burstcount width.
// Signals:
//   avm_address      master->slave  line-aligned burst address
//   avm_writedata    master->slave  current write beat
//   avm_byteenable   master->slave  current beat byte enables
//   avm_burstcount   master->slave  beats in the burst
//   avm_write        master->slave  write command/beat valid
//   avm_read         master->slave  read command valid
//   avm_waitrequest  slave->master  slave stall
//   avm_readdatavalid slave->master read beat valid
//   avm_readdata     slave->master  read beat data
interface avalon_line_master_if #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int BCW = 3
);
    logic [AW-1:0]   avm_address;
    logic [DW-1:0]   avm_writedata;
    logic [DW/8-1:0] avm_byteenable;
    logic [BCW-1:0]  avm_burstcount;
    logic            avm_write;
    logic            avm_read;
    logic            avm_waitrequest;
    logic            avm_readdatavalid;
    logic [DW-1:0]   avm_readdata;

    modport master (
        output avm_address, avm_writedata, avm_byteenable, avm_burstcount,
               avm_write, avm_read,
        input  avm_waitrequest, avm_readdatavalid, avm_readdata
    );

    modport slave (
        input  avm_address, avm_writedata, avm_byteenable, avm_burstcount,
               avm_write, avm_read,
        output avm_waitrequest, avm_readdatavalid, avm_readdata
    );
endinterface

// File: rtl/avalon_line_master.sv
// Avalon-MM burst master moving whole cache lines for the write-line and
// read-line request channels. Writes win when both channels request at once;
// a channel that completed must see its *_do low for one edge before it can
// start another transfer.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_do/wr_done              write-line request / one-cycle completion pulse
//   wr_address, wr_line        write-line address and data (word i at [i*DW +: DW])
//   wr_byteenable              per-beat byte enables (beat i at [i*DW/8 +: DW/8])
//   rd_do/rd_done              read-line request / one-cycle completion pulse
//   rd_address, rd_line        read-line address and last completed read line
//   protocol_error             sticky flag: readdatavalid outside a read data phase
//   avm                        Avalon-MM master bus
module avalon_line_master #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LINE_WORDS = 4,
    parameter int BCW        = $clog2(LINE_WORDS) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_do,
    output logic                         wr_done,
    input  logic [AW-1:0]                wr_address,
    input  logic [DW*LINE_WORDS-1:0]     wr_line,
    input  logic [DW/8*LINE_WORDS-1:0]   wr_byteenable,
    input  logic                         rd_do,
    output logic                         rd_done,
    input  logic [AW-1:0]                rd_address,
    output logic [DW*LINE_WORDS-1:0]     rd_line,
    output logic                         protocol_error,
    avalon_line_master_if.master         avm
);
    localparam int BW  = DW / 8;
    localparam int CW  = $clog2(LINE_WORDS);
    localparam int OFS = $clog2(LINE_WORDS * BW);
    localparam logic [AW-1:0]  ADDR_MASK = {{(AW-OFS){1'b1}}, {OFS{1'b0}}};
    localparam logic [BCW-1:0] BURST     = BCW'(LINE_WORDS);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_RD_CMD  = 3'd2,
        S_RD_DATA = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                     state_r, state_nx_s;
    logic                       wr_armed_r, rd_armed_r;
    logic                       wr_go_s, rd_go_s, wr_fin_s, rd_fin_s, last_s;
    logic [CW-1:0]              cnt_r, cnt_inc_s;
    logic [DW*LINE_WORDS-1:0]   wr_line_r, rd_buf_r, rd_merge_s, rd_line_r;
    logic [BW*LINE_WORDS-1:0]   wr_be_r;
    logic [AW-1:0]              addr_r;
    logic [DW-1:0]              writedata_r;
    logic [BW-1:0]              be_r;
    logic [BCW-1:0]             burstcount_r;
    logic                       write_r, read_r, wr_done_r, rd_done_r, protocol_error_r;

    assign cnt_inc_s = cnt_r + CW'(1);
    assign last_s    = (cnt_r == LAST_BEAT);
    // Completion edges: the last write beat is accepted / the last read beat arrives.
    assign wr_fin_s  = (state_r == S_WRITE) && !avm.avm_waitrequest && last_s;
    assign rd_fin_s  = (state_r == S_RD_DATA) && avm.avm_readdatavalid && last_s;

    // Read line under assembly with the incoming beat dropped into its slot.
    always_comb begin
        rd_merge_s = rd_buf_r;
        rd_merge_s[cnt_r*DW +: DW] = avm.avm_readdata;
    end

    // Next-state logic and channel arbitration (write has priority).
    always_comb begin
        state_nx_s = state_r;
        wr_go_s    = 1'b0;
        rd_go_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (wr_do && wr_armed_r) begin
                    wr_go_s    = 1'b1;
                    state_nx_s = S_WRITE;
                end else if (rd_do && rd_armed_r) begin
                    rd_go_s    = 1'b1;
                    state_nx_s = S_RD_CMD;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_WRITE: begin
                if (wr_fin_s) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_WRITE;
                end
            end
            S_RD_CMD: begin
                if (!avm.avm_waitrequest) begin
                    state_nx_s = S_RD_DATA;
                end else begin
                    state_nx_s = S_RD_CMD;
                end
            end
            S_RD_DATA: begin
                if (rd_fin_s) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_RD_DATA;
                end
            end
            S_DONE:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Registered bus outputs, beat counter, line buffers, arming and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_armed_r       <= 1'b1;
            rd_armed_r       <= 1'b1;
            cnt_r            <= '0;
            wr_line_r        <= '0;
            wr_be_r          <= '0;
            rd_buf_r         <= '0;
            rd_line_r        <= '0;
            addr_r           <= '0;
            writedata_r      <= '0;
            be_r             <= '0;
            burstcount_r     <= '0;
            write_r          <= 1'b0;
            read_r           <= 1'b0;
            wr_done_r        <= 1'b0;
            rd_done_r        <= 1'b0;
            protocol_error_r <= 1'b0;
        end else begin
            wr_done_r        <= wr_fin_s;
            rd_done_r        <= rd_fin_s;
            // A held request after completion stays disarmed until *_do drops.
            wr_armed_r       <= !wr_do || (wr_armed_r && !wr_fin_s);
            rd_armed_r       <= !rd_do || (rd_armed_r && !rd_fin_s);
            protocol_error_r <= protocol_error_r ||
                                (avm.avm_readdatavalid && (state_r != S_RD_DATA));
            case (state_r)
                S_IDLE: begin
                    if (wr_go_s) begin
                        addr_r       <= wr_address & ADDR_MASK;
                        wr_line_r    <= wr_line;
                        wr_be_r      <= wr_byteenable;
                        writedata_r  <= wr_line[DW-1:0];
                        be_r         <= wr_byteenable[BW-1:0];
                        burstcount_r <= BURST;
                        write_r      <= 1'b1;
                        cnt_r        <= '0;
                    end else if (rd_go_s) begin
                        addr_r       <= rd_address & ADDR_MASK;
                        be_r         <= '1;
                        burstcount_r <= BURST;
                        read_r       <= 1'b1;
                        cnt_r        <= '0;
                    end else begin
                        cnt_r        <= '0;
                    end
                end
                S_WRITE: begin
                    if (!avm.avm_waitrequest) begin
                        cnt_r <= cnt_inc_s;
                        if (last_s) begin
                            write_r      <= 1'b0;
                            writedata_r  <= '0;
                            be_r         <= '0;
                            burstcount_r <= '0;
                        end else begin
                            writedata_r  <= wr_line_r[cnt_inc_s*DW +: DW];
                            be_r         <= wr_be_r[cnt_inc_s*BW +: BW];
                        end
                    end
                end
                S_RD_CMD: begin
                    if (!avm.avm_waitrequest) begin
                        read_r       <= 1'b0;
                        be_r         <= '0;
                        burstcount_r <= '0;
                    end
                end
                S_RD_DATA: begin
                    // Waitrequest has no meaning for returning read data.
                    if (avm.avm_readdatavalid) begin
                        rd_buf_r <= rd_merge_s;
                        cnt_r    <= cnt_inc_s;
                        if (last_s) begin
                            rd_line_r <= rd_merge_s;
                        end
                    end
                end
                default: cnt_r <= '0;
            endcase
        end
    end

    assign avm.avm_address    = addr_r;
    assign avm.avm_writedata  = writedata_r;
    assign avm.avm_byteenable = be_r;
    assign avm.avm_burstcount = burstcount_r;
    assign avm.avm_write      = write_r;
    assign avm.avm_read       = read_r;
    assign wr_done            = wr_done_r;
    assign rd_done            = rd_done_r;
    assign rd_line            = rd_line_r;
    assign protocol_error     = protocol_error_r;
endmodule

// File: tb/tb_avalon_line_master.sv
// Self-checking bench for avalon_line_master: one 32-bit/4-word build and one
// 64-bit/8-word build share the stimulus variables; sel_v picks the build
// under test. Expected beats, timing and read lines come from the transfer
// rules (line word slicing, stall and gap counts), not from the RTL.
module tb_avalon_line_master;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    int           sel_v = 0;
    logic         wr_do_v = 1'b0, rd_do_v = 1'b0;
    logic [31:0]  wr_addr = 32'd0, rd_addr = 32'd0;
    logic [511:0] wr_line_v = 512'd0;
    logic [63:0]  wr_be_v = 64'd0;
    logic         wreq = 1'b0, rdv = 1'b0;
    logic [63:0]  rdata = 64'd0;
    int           tests_run = 0, tests_failed = 0;
    int           stalls[8];
    int           gaps[8];
    logic [511:0] last_rd[2];

    logic         wr_done32, rd_done32, perr32, wr_done64, rd_done64, perr64;
    logic [127:0] rd_line32;
    logic [511:0] rd_line64;

    avalon_line_master_if #(.AW(32), .DW(32), .BCW(3)) bus32 ();
    avalon_line_master_if #(.AW(32), .DW(64), .BCW(4)) bus64 ();

    assign bus32.avm_waitrequest   = wreq;
    assign bus32.avm_readdatavalid = rdv && (sel_v == 0);
    assign bus32.avm_readdata      = rdata[31:0];
    assign bus64.avm_waitrequest   = wreq;
    assign bus64.avm_readdatavalid = rdv && (sel_v != 0);
    assign bus64.avm_readdata      = rdata;

    avalon_line_master #(.AW(32), .DW(32), .LINE_WORDS(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .wr_do(wr_do_v && (sel_v == 0)), .wr_done(wr_done32),
        .wr_address(wr_addr), .wr_line(wr_line_v[127:0]), .wr_byteenable(wr_be_v[15:0]),
        .rd_do(rd_do_v && (sel_v == 0)), .rd_done(rd_done32),
        .rd_address(rd_addr), .rd_line(rd_line32),
        .protocol_error(perr32), .avm(bus32)
    );

    avalon_line_master #(.AW(32), .DW(64), .LINE_WORDS(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .wr_do(wr_do_v && (sel_v != 0)), .wr_done(wr_done64),
        .wr_address(wr_addr), .wr_line(wr_line_v), .wr_byteenable(wr_be_v),
        .rd_do(rd_do_v && (sel_v != 0)), .rd_done(rd_done64),
        .rd_address(rd_addr), .rd_line(rd_line64),
        .protocol_error(perr64), .avm(bus64)
    );

    always #5 clk = ~clk;

    // Outputs of the build currently under test, widened to common sizes.
    logic         m_write, m_read, m_wr_done, m_rd_done, m_perr;
    logic [31:0]  m_addr;
    logic [63:0]  m_wdata;
    logic [7:0]   m_be;
    logic [3:0]   m_bc;
    logic [511:0] m_rd_line;
    always_comb begin
        if (sel_v != 0) begin
            m_write = bus64.avm_write;  m_read = bus64.avm_read;
            m_addr  = bus64.avm_address; m_wdata = bus64.avm_writedata;
            m_be    = bus64.avm_byteenable; m_bc = bus64.avm_burstcount;
            m_wr_done = wr_done64; m_rd_done = rd_done64; m_perr = perr64;
            m_rd_line = rd_line64;
        end else begin
            m_write = bus32.avm_write;  m_read = bus32.avm_read;
            m_addr  = bus32.avm_address; m_wdata = {32'd0, bus32.avm_writedata};
            m_be    = {4'd0, bus32.avm_byteenable}; m_bc = {1'b0, bus32.avm_burstcount};
            m_wr_done = wr_done32; m_rd_done = rd_done32; m_perr = perr32;
            m_rd_line = {384'd0, rd_line32};
        end
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero();
        check_eq("rst_write", m_write, 512'd0);
        check_eq("rst_read", m_read, 512'd0);
        check_eq("rst_addr", m_addr, 512'd0);
        check_eq("rst_wdata", m_wdata, 512'd0);
        check_eq("rst_be", m_be, 512'd0);
        check_eq("rst_bc", m_bc, 512'd0);
        check_eq("rst_wr_done", m_wr_done, 512'd0);
        check_eq("rst_rd_done", m_rd_done, 512'd0);
        check_eq("rst_perr", m_perr, 512'd0);
        check_eq("rst_rd_line", m_rd_line, 512'd0);
    endtask

    // Write one line on the selected build; stalls[i] waitrequest cycles before beat i.
    task automatic run_write(input logic [31:0] addr, input logic [511:0] line,
                             input logic [63:0] be, input int hold);
        int lw, dwb, bwb, ofs, beat, left, n, stall_sum;
        logic [31:0] exp_addr;
        logic [63:0] dmask, bmask;
        logic fin;
        lw  = (sel_v != 0) ? 8 : 4;
        dwb = (sel_v != 0) ? 64 : 32;
        bwb = dwb / 8;
        ofs = (sel_v != 0) ? 6 : 4;
        exp_addr = addr & ~((32'd1 << ofs) - 32'd1);
        dmask = (dwb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        bmask = (64'd1 << bwb) - 64'd1;
        stall_sum = 0;
        for (int i = 0; i < lw; i++) stall_sum += stalls[i];
        wr_addr = addr; wr_line_v = line; wr_be_v = be; wr_do_v = 1'b1; wreq = 1'b0;
        beat = 0; left = stalls[0]; fin = 1'b0; n = 0;
        while (!fin && n < 200) begin
            @(negedge clk);
            n++;
            if (beat < lw) begin
                check_eq("wr_write", m_write, 512'd1);
                check_eq("wr_read_idle", m_read, 512'd0);
                check_eq("wr_addr", m_addr, exp_addr);
                check_eq("wr_bcount", m_bc, lw);
                check_eq("wr_data", m_wdata, (line >> (beat * dwb)) & dmask);
                check_eq("wr_be", m_be, (be >> (beat * bwb)) & bmask);
                check_eq("wr_done_early", m_wr_done, 512'd0);
                if (left > 0) begin
                    wreq = 1'b1; left--;
                end else begin
                    wreq = 1'b0; beat++;
                    if (beat < lw) left = stalls[beat];
                end
            end else begin
                wreq = 1'b0;
                check_eq("wr_done", m_wr_done, 512'd1);
                check_eq("wr_done_lat", n, lw + 1 + stall_sum);
                check_eq("wr_write_off", m_write, 512'd0);
                fin = 1'b1;
            end
        end
        check_eq("wr_timeout", fin, 512'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("wr_no_retrigger", m_write, 512'd0);
            check_eq("wr_done_once", m_wr_done, 512'd0);
        end
        wr_do_v = 1'b0;
        @(negedge clk);
        check_eq("wr_idle_write", m_write, 512'd0);
        check_eq("wr_idle_read", m_read, 512'd0);
        check_eq("wr_done_pulse", m_wr_done, 512'd0);
        check_eq("rd_line_kept", m_rd_line, last_rd[sel_v]);
    endtask

    // Read one line; cmd_stall waitrequest cycles, gaps[i] idle cycles before beat i.
    task automatic run_read(input logic [31:0] addr, input logic [511:0] data, input int cmd_stall);
        int lw, dwb, ofs, beat, w, g, n, phase, gap_sum;
        logic [31:0] exp_addr;
        logic [63:0] dmask;
        logic fin;
        lw  = (sel_v != 0) ? 8 : 4;
        dwb = (sel_v != 0) ? 64 : 32;
        ofs = (sel_v != 0) ? 6 : 4;
        exp_addr = addr & ~((32'd1 << ofs) - 32'd1);
        dmask = (dwb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        gap_sum = 0;
        for (int i = 0; i < lw; i++) gap_sum += gaps[i];
        rd_addr = addr; rd_do_v = 1'b1; wreq = 1'b0; rdv = 1'b0;
        phase = 0; w = cmd_stall; beat = 0; g = 0; n = 0; fin = 1'b0;
        while (!fin && n < 300) begin
            @(negedge clk);
            n++;
            case (phase)
                0: begin
                    check_eq("rd_cmd", m_read, 512'd1);
                    check_eq("rd_no_write", m_write, 512'd0);
                    check_eq("rd_addr", m_addr, exp_addr);
                    check_eq("rd_bcount", m_bc, lw);
                    check_eq("rd_be", m_be, (64'd1 << (dwb / 8)) - 64'd1);
                    if (w > 0) begin
                        wreq = 1'b1; w--;
                    end else begin
                        wreq = 1'b0; phase = 1; g = gaps[0];
                    end
                end
                1: begin
                    check_eq("rd_cmd_off", m_read, 512'd0);
                    check_eq("rd_done_early", m_rd_done, 512'd0);
                    check_eq("rd_line_hold", m_rd_line, last_rd[sel_v]);
                    wreq = 1'($urandom_range(0, 1));
                    if (g > 0) begin
                        rdv = 1'b0; g--;
                    end else begin
                        rdv = 1'b1;
                        rdata = (data >> (beat * dwb)) & dmask;
                        beat++;
                        if (beat == lw) phase = 2;
                        else g = gaps[beat];
                    end
                end
                default: begin
                    rdv = 1'b0; wreq = 1'b0;
                    check_eq("rd_done", m_rd_done, 512'd1);
                    check_eq("rd_line", m_rd_line, data);
                    check_eq("rd_done_lat", n, cmd_stall + gap_sum + lw + 2);
                    fin = 1'b1;
                end
            endcase
        end
        check_eq("rd_timeout", fin, 512'd1);
        rd_do_v = 1'b0;
        last_rd[sel_v] = data;
        @(negedge clk);
        check_eq("rd_done_pulse", m_rd_done, 512'd0);
        check_eq("rd_idle_read", m_read, 512'd0);
        check_eq("rd_perr", m_perr, 512'd0);
    endtask

    function automatic logic [511:0] rand_line(input int words32);
        logic [511:0] l;
        l = 512'd0;
        for (int i = 0; i < words32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0] d;
        last_rd[0] = 512'd0;
        last_rd[1] = 512'd0;
        for (int i = 0; i < 8; i++) begin stalls[i] = 0; gaps[i] = 0; end

        repeat (3) @(negedge clk);
        sel_v = 0; #1 check_outputs_zero();
        sel_v = 1; #1 check_outputs_zero();
        sel_v = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain write, wr_do held 3 cycles after completion.
        run_write(32'h0000_0101, 512'h88887777_66665555_44443333_22221111, 64'h0000_0000_0000_FFFF, 3);
        // Same write with waitrequest on beats 0 and 2 for 2 cycles each.
        stalls[0] = 2; stalls[2] = 2;
        run_write(32'h0000_0101, 512'h88887777_66665555_44443333_22221111, 64'h0000_0000_0000_FFFF, 0);
        for (int i = 0; i < 8; i++) stalls[i] = 0;
        // Read with one command stall and a gap after the second beat.
        gaps[2] = 1;
        run_read(32'h0000_0230, 512'h000000A3_000000A2_000000A1_000000A0, 1);
        gaps[2] = 0;
        // Simultaneous requests: write first, then the read.
        rd_addr = 32'h0000_0440; rd_do_v = 1'b1;
        run_write(32'h0000_0300, 512'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 64'h0000_0000_0000_0F3C, 0);
        run_read(32'h0000_0440, 512'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978, 0);

        // Wide build: alternating 0xFF/0x0F byte enables.
        sel_v = 1;
        @(negedge clk);
        run_write(32'h1234_5679, rand_line(16), 64'h0FFF_0FFF_0FFF_0FFF, 1);

        // Randomized transfers on both builds.
        for (int k = 0; k < 8; k++) begin
            sel_v = int'($urandom_range(0, 1));
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                stalls[i] = int'($urandom_range(0, 2));
                gaps[i]   = int'($urandom_range(0, 2));
            end
            d = rand_line(sel_v != 0 ? 16 : 4);
            run_write($urandom, d, {$urandom, $urandom} & ((sel_v != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF),
                      int'($urandom_range(0, 2)));
            d = rand_line(sel_v != 0 ? 16 : 4);
            run_read($urandom, d, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a read, then stray beats from the slave.
        sel_v = 0;
        for (int i = 0; i < 8; i++) begin stalls[i] = 0; gaps[i] = 0; end
        @(negedge clk);
        rd_addr = 32'h0000_0800; rd_do_v = 1'b1; wreq = 1'b0; rdv = 1'b0;
        @(negedge clk);
        check_eq("rst_test_cmd", m_read, 512'd1);
        @(negedge clk);
        rdv = 1'b1; rdata = 64'h0000_00B0;
        @(negedge clk);
        rdata = 64'h0000_00B1;
        @(negedge clk);
        rdv = 1'b0; rd_do_v = 1'b0; rst_n = 1'b0;
        #1 check_outputs_zero();
        repeat (2) @(negedge clk);
        check_outputs_zero();
        rst_n = 1'b1;
        @(negedge clk);
        rdv = 1'b1; rdata = 64'h0000_00B2;
        @(negedge clk);
        rdata = 64'h0000_00B3;
        check_eq("stray_no_done1", m_rd_done, 512'd0);
        check_eq("stray_perr1", m_perr, 512'd1);
        @(negedge clk);
        rdv = 1'b0;
        check_eq("stray_no_done2", m_rd_done, 512'd0);
        @(negedge clk);
        check_eq("stray_perr_sticky", m_perr, 512'd1);
        check_eq("stray_rd_line", m_rd_line, 512'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
